// File: rtl/mod4_mod5_pkg.sv
// Shared types and constants for the alternating mod4/mod5 stream checker.
package mod4_mod5_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [2:0] MOD4_LAST = 3'd3;
  localparam logic [2:0] MOD5_LAST = 3'd4;
  localparam int         PERIOD    = 9;

  // Returns {next_phase, next_value} for one step of the reference sequence.
  function automatic logic [3:0] seq_next(input logic phase, input logic [2:0] value);
    logic [3:0] res;
    if (!phase && value == MOD4_LAST)      res = {1'b1, 3'd0};
    else if (phase && value == MOD5_LAST)  res = {1'b0, 3'd0};
    else                                   res = {phase, value + 3'd1};
    return res;
  endfunction

endpackage

// File: rtl/mod4_mod5_seq_gen.sv
// Expected-value generator: holds the reference position (phase, expected)
// and steps it on advance or rewinds it to the start of the mod4 segment on load.
module mod4_mod5_seq_gen
  import mod4_mod5_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic       phase,
  output logic [2:0] expected
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= 1'b0;
      expected <= 3'd0;
    end else if (load) begin
      phase    <= 1'b0;
      expected <= 3'd0;
    end else if (advance) begin
      {phase, expected} <= seq_next(phase, expected);
    end
  end

endmodule

// File: rtl/mod4_mod5_checker.sv
// Lock checker for a received alternating mod4/mod5 count stream: hunts for the
// mod5 terminal value, confirms LOCK_CNT matches, then flywheels in LOCK.
//
// state | meaning
// HUNT  | waiting for a sample of 4 (end of a mod5 segment)
// SYNC  | counting consecutive matches toward LOCK_CNT
// LOCK  | locked; flywheel advance, mismatches pulse err
module mod4_mod5_checker
  import mod4_mod5_pkg::*;
#(
  parameter int LOCK_CNT = PERIOD,
  parameter int MISS_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [2:0] count_in,
  output logic       locked,
  output logic       err,
  output logic       phase,
  output logic [2:0] expected,
  output logic [7:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int XW = $clog2(MISS_MAX + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [XW-1:0] MISS_LAST  = XW'(MISS_MAX - 1);

  state_t        state, state_nx;
  logic [MW-1:0] match_cnt, match_cnt_nx;
  logic [XW-1:0] miss_cnt, miss_cnt_nx;
  logic          err_nx;
  logic [7:0]    err_cnt_nx;
  logic          seq_load, seq_advance;
  logic          match;

  assign match = (count_in == expected);

  mod4_mod5_seq_gen u_seq_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (seq_load),
    .advance  (seq_advance),
    .phase    (phase),
    .expected (expected)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HUNT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (valid_in) begin
      case (state)
        HUNT: if (count_in == MOD5_LAST) state_nx = SYNC;
        SYNC: begin
          if (!match)                     state_nx = HUNT;
          else if (match_cnt == MATCH_LAST) state_nx = LOCK;
        end
        LOCK: if (!match && miss_cnt == MISS_LAST) state_nx = HUNT;
        default: state_nx = HUNT;
      endcase
    end
  end

  always_comb begin
    seq_load     = 1'b0;
    seq_advance  = 1'b0;
    match_cnt_nx = match_cnt;
    miss_cnt_nx  = miss_cnt;
    err_nx       = 1'b0;
    err_cnt_nx   = err_cnt;
    if (valid_in) begin
      case (state)
        HUNT: begin
          if (count_in == MOD5_LAST) begin
            seq_load     = 1'b1;
            match_cnt_nx = '0;
            miss_cnt_nx  = '0;
          end
        end
        SYNC: begin
          if (match) begin
            seq_advance  = 1'b1;
            match_cnt_nx = (match_cnt == MATCH_LAST) ? '0 : match_cnt + 1'b1;
          end else begin
            match_cnt_nx = '0;
          end
          miss_cnt_nx = '0;
        end
        LOCK: begin
          // Flywheel: the reference keeps running whether or not the sample agrees.
          seq_advance = 1'b1;
          if (match) begin
            miss_cnt_nx = '0;
          end else begin
            err_nx      = 1'b1;
            miss_cnt_nx = (miss_cnt == MISS_LAST) ? '0 : miss_cnt + 1'b1;
            if (err_cnt != 8'hFF) err_cnt_nx = err_cnt + 8'd1;
          end
        end
        default: begin
          match_cnt_nx = '0;
          miss_cnt_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      match_cnt <= match_cnt_nx;
      miss_cnt  <= miss_cnt_nx;
      err       <= err_nx;
      err_cnt   <= err_cnt_nx;
    end
  end

  assign locked = (state == LOCK);

endmodule
